// File: rtl/bus_pkg.sv
// Shared definitions for the two-master bus arbiter: grant-state encoding,
// default bus widths and the slave address map.
package bus_pkg;

    localparam int ADDR_W_DEF   = 16;
    localparam int DATA_W_DEF   = 64;
    localparam int MAX_HOLD_DEF = 8;

    typedef enum logic {
        GNT_M0 = 1'b0,
        GNT_M1 = 1'b1
    } arb_state_e;

    localparam logic [15:0] MEM_LO   = 16'h0000;
    localparam logic [15:0] MEM_HI   = 16'h00FF;
    localparam logic [15:0] RF_LO    = 16'h0110;
    localparam logic [15:0] RF_HI    = 16'h0119;
    localparam logic [15:0] INST_REG = 16'h0110;

    // Hold counter must not wrap back to zero during a very long tenure.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/bus_addr_decoder.sv
// Combinational inclusive-range decoder producing the two slave selects.
module bus_addr_decoder
    import bus_pkg::*;
#(
    parameter int                ADDR_W = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] S0_LO  = ADDR_W'(MEM_LO),
    parameter logic [ADDR_W-1:0] S0_HI  = ADDR_W'(MEM_HI),
    parameter logic [ADDR_W-1:0] S1_LO  = ADDR_W'(RF_LO),
    parameter logic [ADDR_W-1:0] S1_HI  = ADDR_W'(RF_HI)
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic              s0_sel_o,
    output logic              s1_sel_o
);

    // Offset compare: an address below lo wraps to a large offset and fails.
    function automatic logic in_range(input logic [ADDR_W-1:0] a,
                                      input logic [ADDR_W-1:0] lo,
                                      input logic [ADDR_W-1:0] hi);
        logic [ADDR_W-1:0] off;
        off = a - lo;
        return (off <= (hi - lo));
    endfunction

    // Slave select decode
    always_comb begin
        s0_sel_o = in_range(addr_i, S0_LO, S0_HI);
        s1_sel_o = in_range(addr_i, S1_LO, S1_HI);
    end

endmodule

// File: rtl/bus_arbiter_2m.sv
// Two-master shared-bus arbiter with address decode and registered read return.
// Optional forced hand-over after MAX_HOLD cycles: define BUS_ARB_TIMEOUT_EN.
module bus_arbiter_2m
    import bus_pkg::*;
#(
    parameter int                ADDR_W = ADDR_W_DEF,
    parameter int                DATA_W = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] S0_LO  = ADDR_W'(MEM_LO),
    parameter logic [ADDR_W-1:0] S0_HI  = ADDR_W'(MEM_HI),
    parameter logic [ADDR_W-1:0] S1_LO  = ADDR_W'(RF_LO),
    parameter logic [ADDR_W-1:0] S1_HI  = ADDR_W'(RF_HI)
`ifdef BUS_ARB_TIMEOUT_EN
    , parameter int              MAX_HOLD = MAX_HOLD_DEF
`endif
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_dout,
    output logic              m0_grant,
    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_dout,
    output logic              m1_grant,
    output logic [DATA_W-1:0] m_din,
    output logic              s0_sel,
    output logic              s1_sel,
    output logic [ADDR_W-1:0] s_addr,
    output logic              s_wr,
    output logic [DATA_W-1:0] s_din,
    input  logic [DATA_W-1:0] s0_dout,
    input  logic [DATA_W-1:0] s1_dout
);

    arb_state_e        state_q, state_d;
    logic [DATA_W-1:0] m_din_q, m_din_d;
    logic              hold_expired_s;

`ifdef BUS_ARB_TIMEOUT_EN
    logic [7:0] hold_q, hold_d;

    // Hold counter register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_q <= 8'd0;
        end else begin
            hold_q <= hold_d;
        end
    end

    // Tenure length tracking; clears whenever the grant moves
    always_comb begin
        hold_d         = (state_d != state_q) ? 8'd0 : sat_inc8(hold_q);
        hold_expired_s = (hold_q >= 8'(MAX_HOLD - 1));
    end
`else
    // Without the timeout the holder keeps the bus until it releases it
    always_comb begin
        hold_expired_s = 1'b0;
    end
`endif

    // Grant state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= GNT_M0;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant next-state; the bus parks on master 0 when master 1 lets go
    always_comb begin
        state_d = state_q;
        case (state_q)
            GNT_M0: begin
                if (m1_req && (!m0_req || hold_expired_s)) begin
                    state_d = GNT_M1;
                end else begin
                    state_d = GNT_M0;
                end
            end
            GNT_M1: begin
                if (!m1_req || (m0_req && hold_expired_s)) begin
                    state_d = GNT_M0;
                end else begin
                    state_d = GNT_M1;
                end
            end
            default: state_d = GNT_M0;
        endcase
    end

    // Address-phase mux; a holder that is not requesting never writes
    always_comb begin
        s_addr = m0_addr;
        s_din  = m0_dout;
        s_wr   = m0_wr & m0_req;
        case (state_q)
            GNT_M1: begin
                s_addr = m1_addr;
                s_din  = m1_dout;
                s_wr   = m1_wr & m1_req;
            end
            default: begin
                s_addr = m0_addr;
                s_din  = m0_dout;
                s_wr   = m0_wr & m0_req;
            end
        endcase
    end

    bus_addr_decoder #(
        .ADDR_W (ADDR_W),
        .S0_LO  (S0_LO),
        .S0_HI  (S0_HI),
        .S1_LO  (S1_LO),
        .S1_HI  (S1_HI)
    ) u_dec (
        .addr_i   (s_addr),
        .s0_sel_o (s0_sel),
        .s1_sel_o (s1_sel)
    );

    // Read-return select; unmapped addresses read as zero
    always_comb begin
        if (s0_sel) begin
            m_din_d = s0_dout;
        end else if (s1_sel) begin
            m_din_d = s1_dout;
        end else begin
            m_din_d = {DATA_W{1'b0}};
        end
    end

    // Read data register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_din_q <= {DATA_W{1'b0}};
        end else begin
            m_din_q <= m_din_d;
        end
    end

    assign m_din    = m_din_q;
    assign m0_grant = (state_q == GNT_M0);
    assign m1_grant = (state_q == GNT_M1);

endmodule

// File: tb/tb_bus_arbiter_2m.sv
// Self-checking bench for bus_arbiter_2m: directed scenarios plus random
// traffic compared every cycle against a behavioural ownership model.
module tb_bus_arbiter_2m;
    import bus_pkg::*;

    localparam int AW = 16;
    localparam int DW = 64;
`ifdef BUS_ARB_TIMEOUT_EN
    localparam int HOLD_LIM = MAX_HOLD_DEF;
`else
    localparam int HOLD_LIM = 0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          m0_req = 1'b0, m0_wr = 1'b0, m1_req = 1'b0, m1_wr = 1'b0;
    logic [AW-1:0] m0_addr = '0, m1_addr = '0;
    logic [DW-1:0] m0_dout = '0, m1_dout = '0, s0_dout = '0, s1_dout = '0;
    logic          m0_grant, m1_grant, s0_sel, s1_sel, s_wr;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] m_din, s_din;

    int errs = 0;
    int checks = 0;

    // Behavioural model: who owns the bus, for how long, and what reads back next
    int            owner_m = 0;
    int            held_m = 0;
    logic [DW-1:0] din_m = '0;

    logic [AW-1:0] addr_tab [10] = '{16'h0000, 16'h00FF, 16'h0100, 16'h010F, 16'h0110,
                                     16'h0119, 16'h011A, 16'h0200, 16'hFFFF, 16'h0080};

    always #5 clk = ~clk;

    bus_arbiter_2m dut (
        .clk(clk), .reset_n(reset_n),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_dout(m0_dout), .m0_grant(m0_grant),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_dout(m1_dout), .m1_grant(m1_grant),
        .m_din(m_din), .s0_sel(s0_sel), .s1_sel(s1_sel), .s_addr(s_addr), .s_wr(s_wr),
        .s_din(s_din), .s0_dout(s0_dout), .s1_dout(s1_dout)
    );

    initial begin
        assert (int'(MEM_HI) < int'(RF_LO) || int'(RF_HI) < int'(MEM_LO))
            else $error("FAIL range_overlap: memory and register-file windows overlap");
    end

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic bit in_win(input int a, input int lo, input int hi);
        return (a >= lo) && (a <= hi);
    endfunction

    function automatic logic [AW-1:0] e_addr();
        return (owner_m == 1) ? m1_addr : m0_addr;
    endfunction

    function automatic logic e_wr();
        return (owner_m == 1) ? (m1_wr && m1_req) : (m0_wr && m0_req);
    endfunction

    function automatic logic [DW-1:0] e_rd();
        if (in_win(int'(e_addr()), int'(MEM_LO), int'(MEM_HI))) return s0_dout;
        if (in_win(int'(e_addr()), int'(RF_LO), int'(RF_HI)))   return s1_dout;
        return '0;
    endfunction

    function automatic int next_owner();
        bit hreq, oreq, forced;
        hreq   = (owner_m == 1) ? m1_req : m0_req;
        oreq   = (owner_m == 1) ? m0_req : m1_req;
        forced = (HOLD_LIM > 0) && (held_m >= HOLD_LIM - 1);
        if (!hreq && (owner_m == 1 || oreq)) return 1 - owner_m;
        if (forced && oreq) return 1 - owner_m;
        return owner_m;
    endfunction

    // Model update at each edge; reset returns ownership to master 0 at once
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_m <= 0;
            held_m  <= 0;
            din_m   <= '0;
        end else begin
            din_m   <= e_rd();
            owner_m <= next_owner();
            held_m  <= (next_owner() != owner_m) ? 0 : ((held_m < 255) ? held_m + 1 : 255);
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        chk("m0_grant", m0_grant, (owner_m == 0));
        chk("m1_grant", m1_grant, (owner_m == 1));
        chk("m_din", m_din, din_m);
        chk("s_addr", s_addr, e_addr());
        chk("s_wr", s_wr, e_wr());
        chk("s_din", s_din, (owner_m == 1) ? m1_dout : m0_dout);
        chk("s0_sel", s0_sel, in_win(int'(e_addr()), int'(MEM_LO), int'(MEM_HI)));
        chk("s1_sel", s1_sel, in_win(int'(e_addr()), int'(RF_LO), int'(RF_HI)));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Short reset pulse inside the current cycle, well before the next edge
    task automatic pulse_reset();
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
    endtask

    // Consecutive master-0 cycles observed before master 1 first gets the bus
    task automatic count_m0(output int n);
        bit seen;
        n = 0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m1_grant) seen = 1'b1;
            else if (!seen) n++;
            tick();
        end
    endtask

    function automatic logic [AW-1:0] pick_addr();
        case ($urandom_range(3))
            0:       return AW'($urandom);
            1:       return RF_LO + AW'($urandom_range(9));
            default: return addr_tab[$urandom_range(9)];
        endcase
    endfunction

    initial begin
        int n;
        s0_dout = 64'h1111;
        s1_dout = 64'h2222;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_m0_grant", m0_grant, 64'd1);
        chk("rst_m1_grant", m1_grant, 64'd0);
        chk("rst_m_din", m_din, 64'd0);
        #1 reset_n = 1'b1;
        tick();

        // Write to register file from master 0 is visible in the same cycle
        m0_req = 1'b1; m0_wr = 1'b1; m0_addr = INST_REG + 16'h0002; m0_dout = 64'hDEAD_BEEF;
        s1_dout = 64'd0;
        @(negedge clk);
        chk("t1_m0_grant", m0_grant, 64'd1);
        chk("t1_s1_sel", s1_sel, 64'd1);
        chk("t1_s0_sel", s0_sel, 64'd0);
        chk("t1_s_wr", s_wr, 64'd1);
        chk("t1_s_din", s_din, 64'hDEAD_BEEF);
        tick();

        // Read returns one cycle after the address phase
        m0_wr = 1'b0; s1_dout = 64'hDEAD_BEEF;
        @(negedge clk);
        chk("t2_before", m_din, 64'd0);
        tick();
        s1_dout = 64'h5;
        @(negedge clk);
        chk("t2_after", m_din, 64'hDEAD_BEEF);
        tick();

        // Both request: master 0 keeps the bus until it releases
        pulse_reset();
        m0_req = 1'b1; m1_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_hold_m0", m0_grant, 64'd1);
            tick();
        end
        m0_req = 1'b0;
        @(negedge clk);
        chk("t3_not_early", m1_grant, 64'd0);
        tick();
        @(negedge clk);
        chk("t3_m1_grant", m1_grant, 64'd1);
        tick();

        // Master 1 holds against master 0, then releases
        m0_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_hold_m1", m1_grant, 64'd1);
            tick();
        end
        m1_req = 1'b0;
        @(negedge clk);
        chk("t4_release_cycle", m1_grant, 64'd1);
        tick();
        @(negedge clk);
        chk("t4_m0_back", m0_grant, 64'd1);
        tick();

        // Unmapped address: no select, reads back zero
        m0_addr = 16'h0200; m0_wr = 1'b1;
        s0_dout = 64'hAAAA_AAAA_AAAA_AAAA; s1_dout = 64'h5555_5555_5555_5555;
        @(negedge clk);
        chk("t5_s0_sel", s0_sel, 64'd0);
        chk("t5_s1_sel", s1_sel, 64'd0);
        tick();
        @(negedge clk);
        chk("t5_m_din", m_din, 64'd0);
        tick();

        // Contended tenure length, then asynchronous reset while master 1 holds
        pulse_reset();
        m0_req = 1'b1; m1_req = 1'b1; m0_wr = 1'b0;
        count_m0(n);
        chk("t6_tenure", 64'(n), (HOLD_LIM > 0) ? 64'(HOLD_LIM) : 64'd20);
        m0_req = 1'b0; m1_req = 1'b1;
        tick();
        m0_req = 1'b1; m0_wr = 1'b1; m1_wr = 1'b0;
        @(negedge clk);
        chk("t6_m1_holds", m1_grant, 64'd1);
        tick();
        reset_n = 1'b0;
        #1;
        chk("t6_async_grant", m0_grant, 64'd1);
        chk("t6_async_s_wr", s_wr, 64'd1);
        chk("t6_async_m_din", m_din, 64'd0);
        #1 reset_n = 1'b1;
        m0_wr = 1'b0;
        count_m0(n);
        chk("t6_tenure_after_rst", 64'(n), (HOLD_LIM > 0) ? 64'(HOLD_LIM) : 64'd20);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(3) == 0) m0_req = ~m0_req;
            if ($urandom_range(3) == 0) m1_req = ~m1_req;
            m0_wr   = 1'($urandom);
            m1_wr   = 1'($urandom);
            m0_addr = pick_addr();
            m1_addr = pick_addr();
            m0_dout = {$urandom, $urandom};
            m1_dout = {$urandom, $urandom};
            s0_dout = {$urandom, $urandom};
            s1_dout = {$urandom, $urandom};
            if ($urandom_range(199) == 0) begin
                reset_n = 1'b0;
                #1;
                chk("rnd_async_grant", m0_grant, 64'd1);
                chk("rnd_async_m_din", m_din, 64'd0);
                #1 reset_n = 1'b1;
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errs);
        $fatal(1, "watchdog");
    end

endmodule
